mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
Memory-access stage directly downstream of the execute ALU. It takes the ALU result as the effective address (loads/stores) or as the writeback value (all other ops). It performs a req/ack transaction with data memory, handling byte-lane strobes and load sign/zero extension, and presents one registered result per instruction to writeback. While a memory transaction is outstanding it back-pressures execute via in_ready.

Parameters:
MEM_TIMEOUT, 255, max cycles in WAIT without mem_ack before abort; legal range 1..65535.

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  synchronous, active-high reset
in_valid  in  1  execute presents an instruction this cycle
in_ready  out  1  stage can accept; equals (state==IDLE)
is_load  in  1  instruction is a load
is_store  in  1  instruction is a store
funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
alu_result  in  32  effective address or non-memory result
store_data  in  32  rs2 value for stores
rd_in  in  5  destination register
reg_write_in  in  1  instruction writes rd
mem_req  out  1  registered; held high from issue until ack/abort
mem_we  out  1  1 = store, 0 = load; stable while mem_req
mem_addr  out  32  word address {alu_result[31:2],2'b00}
mem_wdata  out  32  store data replicated to selected lanes
mem_wstrb  out  4  byte enables; 0000 for loads
mem_ack  in  1  one-cycle completion pulse; mem_rdata valid same cycle
mem_rdata  in  32  load word
wb_valid  out  1  one-cycle pulse: result registers valid
wb_data  out  32  writeback value
wb_rd  out  5  destination register
wb_reg_write  out  1  forced 0 for stores and errors
wb_err  out  1  access fault (timeout, illegal funct3, misaligned when enabled)

Behaviour:
- Reset: state=IDLE, timeout counter=0; in_ready=1 in the cycle after RST deasserts; all outputs (mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, wb_valid, wb_data, wb_rd, wb_reg_write, wb_err) = 0. RST mid-transaction aborts it, drops mem_req next edge, and emits no wb_valid. mem_ack arriving in IDLE is ignored.
- FSM states: IDLE, WAIT.
- Accept condition: in_valid & in_ready.
- Accept of a non-memory op (is_load=is_store=0): stay IDLE. Next cycle: wb_valid=1, wb_data=alu_result, wb_reg_write=reg_write_in. Latency 1.
- Accept of a memory op: go to WAIT and assert mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb on the next edge.
- If is_load and is_store are both 1, the instruction is treated as a load.
- Illegal funct3 (load 011/110/111; store anything other than 000/001/010): no memory request; stay IDLE; next cycle wb_valid=1, wb_err=1, wb_reg_write=0.
- Strobes, where a = alu_result[1:0]:
  - SB: 0001<<a, wdata={4{store_data[7:0]}}.
  - SH: 0011<<{a[1],1'b0}, wdata={2{store_data[15:0]}}.
  - SW: 1111, wdata=store_data.
- Without MISALIGN_TRAP_EN, H uses a[1] only and W ignores a.
- Load extract: byte/half lane selected by a (halfword by a[1]). LB/LH sign-extend, LBU/LHU zero-extend, LW uses the full word.
- WAIT with mem_ack=1: next edge → IDLE, mem_req=0, wb_valid=1. Loads write the extracted data with wb_reg_write=reg_write_in. Stores write wb_data=0 with wb_reg_write=0.
- WAIT timeout: counter increments each WAIT cycle without ack. At MEM_TIMEOUT: → IDLE, mem_req=0, wb_valid=1, wb_err=1, wb_reg_write=0.
- Latency: memory op total latency = cycles to ack + 1. A new instruction can be accepted in the same cycle wb_valid pulses.
- wb_data, wb_rd and wb_err hold their values until the next wb_valid.

Optional Feature:
MISALIGN_TRAP_EN: when defined, an H access with a[0]=1 or a W access with a≠00 issues no request and takes the illegal-funct3 error path (wb_err=1 next cycle). When undefined, misaligned accesses are silently aligned as described above.

Test Plan:
- Non-memory op: alu_result=0x12345678, rd=5, reg_write=1 → next cycle wb_valid=1, wb_data=0x12345678, wb_rd=5, in_ready stays 1.
- LB from 0x103, ack after 3 cycles with rdata=0x80FFFFFF → mem_addr=0x100, mem_wstrb=0000, wb_data=0xFFFFFF80; LBU same → 0x00000080; in_ready=0 throughout WAIT.
- SH store_data=0xAAAABEEF to 0x202 → mem_we=1, mem_wstrb=1100, mem_wdata=0xBEEFBEEF, wb_reg_write=0.
- MEM_TIMEOUT=4, no ack → mem_req drops after 4 WAIT cycles, wb_err=1; a late mem_ack in IDLE is ignored.
- RST asserted during WAIT → mem_req=0 and state=IDLE next cycle, no wb_valid; a following LW completes normally.
- With MISALIGN_TRAP_EN, LW at 0x101 → mem_req never asserts, wb_err=1; without the macro → mem_addr=0x100, normal completion.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access stage: turns the execute result into a data-memory req/ack
// transaction (loads/stores) or a direct writeback (everything else), and
// presents one registered writeback pulse per instruction.
// Optional build macro: MISALIGN_TRAP_EN (trap misaligned H/W accesses).
module mem_access_stage #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  input  logic        reg_write_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        wb_err
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  logic             accept, mem_op, illegal, misalign, fault, issue, timeout_hit;
  logic [1:0]       a;
  logic [3:0]       wstrb_c;
  logic [XLEN-1:0]  wdata_c;
  logic [XLEN-1:0]  load_val;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;

  // Context of the outstanding access, captured at issue
  logic             pend_load, pend_load_d;
  logic [2:0]       pend_f3, pend_f3_d;
  logic [1:0]       pend_a, pend_a_d;
  logic [4:0]       pend_rd, pend_rd_d;
  logic             pend_rw, pend_rw_d;

  // Next values of the registered outputs
  logic             mem_req_d, mem_we_d;
  logic [XLEN-1:0]  mem_addr_d, mem_wdata_d;
  logic [3:0]       mem_wstrb_d;
  logic             wb_valid_d, wb_reg_write_d, wb_err_d;
  logic [XLEN-1:0]  wb_data_d;
  logic [4:0]       wb_rd_d;

  assign in_ready    = (state_q == ST_IDLE);
  assign accept      = in_valid & in_ready;
  assign mem_op      = is_load | is_store;
  assign a           = alu_result[1:0];
  assign fault       = illegal | misalign;
  assign issue       = accept & mem_op & ~fault;
  assign timeout_hit = (tmo_cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  // Access legality: a load wins when both load and store are flagged
  always_comb begin
    illegal = 1'b0;
    if (is_load) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = 1'b0;
        default:                                illegal = 1'b1;
      endcase
    end else if (is_store) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: illegal = 1'b0;
        default:                illegal = 1'b1;
      endcase
    end
  end

  // Misaligned halfword/word accesses either trap or are silently aligned
  always_comb begin
`ifdef MISALIGN_TRAP_EN
    misalign = mem_op & (((funct3[1:0] == 2'b01) & a[0]) |
                         ((funct3[1:0] == 2'b10) & (a != 2'b00)));
`else
    misalign = 1'b0;
`endif
  end

  // Store lane strobes and lane-replicated write data
  always_comb begin
    wstrb_c = 4'b0000;
    wdata_c = '0;
    if (!is_load) begin
      case (funct3[1:0])
        2'b00: begin
          wstrb_c = 4'b0001 << a;
          wdata_c = {4{store_data[7:0]}};
        end
        2'b01: begin
          wstrb_c = 4'b0011 << {a[1], 1'b0};
          wdata_c = {2{store_data[15:0]}};
        end
        2'b10: begin
          wstrb_c = 4'b1111;
          wdata_c = store_data;
        end
        default: begin
          wstrb_c = 4'b0000;
          wdata_c = '0;
        end
      endcase
    end
  end

  // Load lane extraction with sign/zero extension
  always_comb begin
    case (pend_a)
      2'b00:   byte_sel = mem_rdata[7:0];
      2'b01:   byte_sel = mem_rdata[15:8];
      2'b10:   byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = pend_a[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (pend_f3)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_val = {24'd0, byte_sel};
      3'b101:  load_val = {16'd0, half_sel};
      default: load_val = mem_rdata;
    endcase
  end

  // State register and wait-cycle counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // Next state: leave WAIT on ack or when the wait budget runs out
  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (issue) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_ack || timeout_hit) state_d = ST_IDLE;
        else                        tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: next values of bus, writeback and pending-context registers
  always_comb begin
    mem_req_d      = mem_req;
    mem_we_d       = mem_we;
    mem_addr_d     = mem_addr;
    mem_wdata_d    = mem_wdata;
    mem_wstrb_d    = mem_wstrb;
    wb_valid_d     = 1'b0;
    wb_data_d      = wb_data;
    wb_rd_d        = wb_rd;
    wb_reg_write_d = wb_reg_write;
    wb_err_d       = wb_err;
    pend_load_d    = pend_load;
    pend_f3_d      = pend_f3;
    pend_a_d       = pend_a;
    pend_rd_d      = pend_rd;
    pend_rw_d      = pend_rw;
    case (state_q)
      ST_IDLE: begin
        if (accept && !mem_op) begin
          wb_valid_d     = 1'b1;
          wb_data_d      = alu_result;
          wb_rd_d        = rd_in;
          wb_reg_write_d = reg_write_in;
          wb_err_d       = 1'b0;
        end else if (accept && fault) begin
          wb_valid_d     = 1'b1;
          wb_data_d      = '0;
          wb_rd_d        = rd_in;
          wb_reg_write_d = 1'b0;
          wb_err_d       = 1'b1;
        end else if (issue) begin
          mem_req_d   = 1'b1;
          mem_we_d    = ~is_load;
          mem_addr_d  = {alu_result[31:2], 2'b00};
          mem_wdata_d = wdata_c;
          mem_wstrb_d = wstrb_c;
          pend_load_d = is_load;
          pend_f3_d   = funct3;
          pend_a_d    = a;
          pend_rd_d   = rd_in;
          pend_rw_d   = reg_write_in;
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          mem_req_d      = 1'b0;
          wb_valid_d     = 1'b1;
          wb_rd_d        = pend_rd;
          wb_err_d       = 1'b0;
          wb_data_d      = pend_load ? load_val : '0;
          wb_reg_write_d = pend_load & pend_rw;
        end else if (timeout_hit) begin
          mem_req_d      = 1'b0;
          wb_valid_d     = 1'b1;
          wb_rd_d        = pend_rd;
          wb_err_d       = 1'b1;
          wb_data_d      = '0;
          wb_reg_write_d = 1'b0;
        end
      end
      default: mem_req_d = 1'b0;
    endcase
  end

  // Output and pending-context registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      wb_err       <= 1'b0;
      pend_load    <= 1'b0;
      pend_f3      <= '0;
      pend_a       <= '0;
      pend_rd      <= '0;
      pend_rw      <= 1'b0;
    end else begin
      mem_req      <= mem_req_d;
      mem_we       <= mem_we_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      mem_wstrb    <= mem_wstrb_d;
      wb_valid     <= wb_valid_d;
      wb_data      <= wb_data_d;
      wb_rd        <= wb_rd_d;
      wb_reg_write <= wb_reg_write_d;
      wb_err       <= wb_err_d;
      pend_load    <= pend_load_d;
      pend_f3      <= pend_f3_d;
      pend_a       <= pend_a_d;
      pend_rd      <= pend_rd_d;
      pend_rw      <= pend_rw_d;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, hand-written corner
// sequences (timeout + late ack, reset mid-transaction) and random traffic
// checked against a transaction-level reference model.
module tb_mem_access_stage;

  localparam int unsigned TMO = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid, in_ready, is_load, is_store, reg_write_in;
  logic [2:0]  funct3;
  logic [31:0] alu_result, store_data;
  logic [4:0]  rd_in;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        wb_valid, wb_reg_write, wb_err;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;

  int checks   = 0;
  int failures = 0;
  logic [4:0] last_rd;
  logic       last_err;

  mem_access_stage #(.MEM_TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3),
    .alu_result(alu_result), .store_data(store_data), .rd_in(rd_in),
    .reg_write_in(reg_write_in), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_err(wb_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
  } instr_t;

  // kind: 0 = non-memory, 1 = immediate error, 2 = memory access
  typedef struct {
    int          kind;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] data;
    logic        rw;
  } exp_t;

  typedef struct {
    instr_t      in;
    int          delay;
    logic [31:0] rdata;
    exp_t        e;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic instr_t mk_in(logic ld, logic st, logic [2:0] f3, logic [31:0] alu,
                                   logic [31:0] sd, logic [4:0] rd, logic rw);
    instr_t t;
    t.ld = ld; t.st = st; t.f3 = f3; t.alu = alu; t.sd = sd; t.rd = rd; t.rw = rw;
    return t;
  endfunction

  function automatic exp_t mk_exp(int kind, logic we, logic [31:0] addr, logic [31:0] wdata,
                                  logic [3:0] wstrb, logic [31:0] data, logic rw);
    exp_t e;
    e.kind = kind; e.we = we; e.addr = addr; e.wdata = wdata; e.wstrb = wstrb;
    e.data = data; e.rw = rw;
    return e;
  endfunction

  // Reference model: result of one instruction given the word memory returns
  function automatic exp_t model(instr_t t, logic [31:0] rdata);
    exp_t e;
    int size, a, off;
    logic ld, st, legal;
    longint unsigned mask, v;
    e = mk_exp(0, 1'b0, 32'd0, 32'd0, 4'd0, 32'd0, 1'b0);
    ld = t.ld;
    st = t.st & ~t.ld;
    if (!ld && !st) begin
      e.data = t.alu;
      e.rw   = t.rw;
      return e;
    end
    case (t.f3[1:0])
      2'd0:    size = 1;
      2'd1:    size = 2;
      2'd2:    size = 4;
      default: size = 0;
    endcase
    legal = ld ? (t.f3 != 3'b011 && t.f3 < 3'b110) : (t.f3 < 3'b011);
    a = int'(t.alu & 32'd3);
`ifdef MISALIGN_TRAP_EN
    if (legal && (a % size) != 0) legal = 1'b0;
`endif
    if (!legal) begin
      e.kind = 1;
      return e;
    end
    e.kind = 2;
    e.we   = st;
    e.addr = t.alu & ~32'd3;
    off    = a - (a % size);
    if (st) begin
      e.wstrb = 4'(((1 << size) - 1) << off);
      if (size == 1)      e.wdata = {24'd0, t.sd[7:0]} * 32'h01010101;
      else if (size == 2) e.wdata = {16'd0, t.sd[15:0]} * 32'h00010001;
      else                e.wdata = t.sd;
    end else begin
      mask = (64'd1 << (8 * size)) - 64'd1;
      v    = (64'(rdata) >> (8 * off)) & mask;
      if (!t.f3[2] && size < 4 && ((v >> (8 * size - 1)) & 64'd1) != 64'd0)
        v = v | (~mask & 64'hFFFF_FFFF);
      e.data = 32'(v);
      e.rw   = t.rw;
    end
    return e;
  endfunction

  // Issue one instruction, play memory with 'delay' no-ack cycles, check writeback
  task automatic run_instr(input instr_t t, input int delay, input logic [31:0] rdata,
                           input exp_t e, input string tag);
    bit timed_out;
    int n;
    in_valid = 1'b1; is_load = t.ld; is_store = t.st; funct3 = t.f3;
    alu_result = t.alu; store_data = t.sd; rd_in = t.rd; reg_write_in = t.rw;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    if (e.kind != 2) begin
      chk({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
      chk({tag, ".no_req"}, 32'(mem_req), 32'd0);
      chk({tag, ".ready"}, 32'(in_ready), 32'd1);
      chk({tag, ".err"}, 32'(wb_err), 32'(e.kind == 1));
      chk({tag, ".rd"}, 32'(wb_rd), 32'(t.rd));
      chk({tag, ".reg_write"}, 32'(wb_reg_write), 32'(e.kind == 0 ? e.rw : 1'b0));
      if (e.kind == 0) chk({tag, ".data"}, wb_data, e.data);
      last_err = (e.kind == 1);
    end else begin
      chk({tag, ".req"}, 32'(mem_req), 32'd1);
      chk({tag, ".we"}, 32'(mem_we), 32'(e.we));
      chk({tag, ".addr"}, mem_addr, e.addr);
      chk({tag, ".wstrb"}, 32'(mem_wstrb), 32'(e.wstrb));
      if (e.we) chk({tag, ".wdata"}, mem_wdata, e.wdata);
      chk({tag, ".busy"}, 32'(in_ready), 32'd0);
      chk({tag, ".no_wb"}, 32'(wb_valid), 32'd0);
      timed_out = (delay >= int'(TMO));
      n = timed_out ? int'(TMO) : delay;
      for (int i = 0; i < n; i++) begin
        @(posedge CLK); #1;
        if (!(timed_out && i == n - 1)) begin
          chk({tag, ".req_hold"}, 32'(mem_req), 32'd1);
          chk({tag, ".busy_hold"}, 32'(in_ready), 32'd0);
        end
      end
      if (!timed_out) begin
        mem_ack = 1'b1; mem_rdata = rdata;
        @(posedge CLK); #1;
        mem_ack = 1'b0; mem_rdata = $urandom;
      end
      chk({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
      chk({tag, ".req_drop"}, 32'(mem_req), 32'd0);
      chk({tag, ".ready"}, 32'(in_ready), 32'd1);
      chk({tag, ".err"}, 32'(wb_err), 32'(timed_out));
      chk({tag, ".rd"}, 32'(wb_rd), 32'(t.rd));
      chk({tag, ".reg_write"}, 32'(wb_reg_write), timed_out ? 32'd0 : 32'(e.rw));
      if (!timed_out) chk({tag, ".data"}, wb_data, e.data);
      last_err = timed_out;
    end
    last_rd = t.rd;
  endtask

  task automatic idle_check(input string tag);
    @(posedge CLK); #1;
    chk({tag, ".idle_no_wb"}, 32'(wb_valid), 32'd0);
    chk({tag, ".idle_rd_hold"}, 32'(wb_rd), 32'(last_rd));
    chk({tag, ".idle_err_hold"}, 32'(wb_err), 32'(last_err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    vec_t v;
    instr_t t;
    exp_t e;
    logic [31:0] rd_word, held_data;
    int dsel, delay;

    RST = 1'b1; in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0;
    alu_result = 32'd0; store_data = 32'd0; rd_in = 5'd0; reg_write_in = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    last_rd = 5'd0; last_err = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK); #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.mem_bus", {mem_req, mem_we, mem_wstrb, 26'd0}, 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'd0);
    chk("rst.wb_flags", {wb_valid, wb_reg_write, wb_err, wb_rd, 24'd0}, 32'd0);
    chk("rst.wb_data", wb_data, 32'd0);

    // Directed vectors with hand-derived expectations
    v.in = mk_in(0, 0, 3'b000, 32'h1234_5678, 32'h0, 5'd5, 1); v.delay = 0; v.rdata = 0;
    v.e = mk_exp(0, 0, 0, 0, 4'h0, 32'h1234_5678, 1); vecs.push_back(v);
    v.in = mk_in(1, 0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 1); v.delay = 2; v.rdata = 32'h80FF_FFFF;
    v.e = mk_exp(2, 0, 32'h100, 0, 4'h0, 32'hFFFF_FF80, 1); vecs.push_back(v);
    v.in = mk_in(1, 0, 3'b100, 32'h0000_0103, 32'h0, 5'd8, 1); v.delay = 2; v.rdata = 32'h80FF_FFFF;
    v.e = mk_exp(2, 0, 32'h100, 0, 4'h0, 32'h0000_0080, 1); vecs.push_back(v);
    v.in = mk_in(0, 1, 3'b001, 32'h0000_0202, 32'hAAAA_BEEF, 5'd9, 1); v.delay = 1; v.rdata = 0;
    v.e = mk_exp(2, 1, 32'h200, 32'hBEEF_BEEF, 4'hC, 32'h0, 0); vecs.push_back(v);
    v.in = mk_in(0, 1, 3'b000, 32'h0000_0301, 32'h1234_56A5, 5'd10, 0); v.delay = 0; v.rdata = 0;
    v.e = mk_exp(2, 1, 32'h300, 32'hA5A5_A5A5, 4'h2, 32'h0, 0); vecs.push_back(v);
    v.in = mk_in(0, 1, 3'b010, 32'h0000_040C, 32'hDEAD_BEEF, 5'd11, 1); v.delay = 2; v.rdata = 0;
    v.e = mk_exp(2, 1, 32'h40C, 32'hDEAD_BEEF, 4'hF, 32'h0, 0); vecs.push_back(v);
    v.in = mk_in(1, 0, 3'b001, 32'h0000_0502, 32'h0, 5'd12, 1); v.delay = 1; v.rdata = 32'h8001_7FFF;
    v.e = mk_exp(2, 0, 32'h500, 0, 4'h0, 32'hFFFF_8001, 1); vecs.push_back(v);
    v.in = mk_in(1, 0, 3'b101, 32'h0000_0500, 32'h0, 5'd13, 1); v.delay = 0; v.rdata = 32'h8001_7FFF;
    v.e = mk_exp(2, 0, 32'h500, 0, 4'h0, 32'h0000_7FFF, 1); vecs.push_back(v);
    v.in = mk_in(1, 0, 3'b010, 32'h0000_0600, 32'h0, 5'd14, 1); v.delay = TMO; v.rdata = 0;
    v.e = mk_exp(2, 0, 32'h600, 0, 4'h0, 32'h0, 0); vecs.push_back(v);
    v.in = mk_in(1, 0, 3'b011, 32'h0000_0700, 32'h0, 5'd15, 1); v.delay = 0; v.rdata = 0;
    v.e = mk_exp(1, 0, 0, 0, 4'h0, 32'h0, 0); vecs.push_back(v);
    v.in = mk_in(0, 1, 3'b100, 32'h0000_0700, 32'h5555_5555, 5'd16, 1); v.delay = 0; v.rdata = 0;
    v.e = mk_exp(1, 0, 0, 0, 4'h0, 32'h0, 0); vecs.push_back(v);
    v.in = mk_in(1, 1, 3'b010, 32'h0000_0704, 32'h1111_1111, 5'd17, 1); v.delay = 1; v.rdata = 32'hCAFE_F00D;
    v.e = mk_exp(2, 0, 32'h704, 0, 4'h0, 32'hCAFE_F00D, 1); vecs.push_back(v);
    v.in = mk_in(1, 0, 3'b010, 32'h0000_0101, 32'h0, 5'd18, 1); v.delay = 1; v.rdata = 32'h1122_3344;
`ifdef MISALIGN_TRAP_EN
    v.e = mk_exp(1, 0, 0, 0, 4'h0, 32'h0, 0);
`else
    v.e = mk_exp(2, 0, 32'h100, 0, 4'h0, 32'h1122_3344, 1);
`endif
    vecs.push_back(v);
    v.in = mk_in(1, 0, 3'b000, 32'h0000_0001, 32'h0, 5'd19, 0); v.delay = 0; v.rdata = 32'h0000_7F00;
    v.e = mk_exp(2, 0, 32'h0, 0, 4'h0, 32'h0000_007F, 0); vecs.push_back(v);
    v.in = mk_in(0, 0, 3'b111, 32'hFFFF_FFFF, 32'h0, 5'd31, 0); v.delay = 0; v.rdata = 0;
    v.e = mk_exp(0, 0, 0, 0, 4'h0, 32'hFFFF_FFFF, 0); vecs.push_back(v);

    foreach (vecs[i]) run_instr(vecs[i].in, vecs[i].delay, vecs[i].rdata, vecs[i].e,
                                $sformatf("vec%0d", i));

    // Writeback fields hold through an idle cycle
    held_data = wb_data;
    idle_check("hold");
    chk("hold.data", wb_data, held_data);

    // Timeout, then a late ack in IDLE must be ignored
    t = mk_in(1, 0, 3'b010, 32'h0000_0800, 32'h0, 5'd20, 1);
    run_instr(t, TMO, 32'h0, model(t, 32'h0), "tmo");
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    @(posedge CLK); #1;
    mem_ack = 1'b0;
    chk("late_ack.no_wb", 32'(wb_valid), 32'd0);
    chk("late_ack.no_req", 32'(mem_req), 32'd0);
    chk("late_ack.ready", 32'(in_ready), 32'd1);
    chk("late_ack.err_hold", 32'(wb_err), 32'd1);
    idle_check("late_ack");

    // Reset in the middle of an outstanding load
    in_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
    alu_result = 32'h0000_0900; rd_in = 5'd21; reg_write_in = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    chk("rst_wait.req", 32'(mem_req), 32'd1);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("rst_wait.req_drop", 32'(mem_req), 32'd0);
    chk("rst_wait.ready", 32'(in_ready), 32'd1);
    chk("rst_wait.no_wb", 32'(wb_valid), 32'd0);
    last_rd = 5'd0; last_err = 1'b0;
    idle_check("rst_wait");
    t = mk_in(1, 0, 3'b010, 32'h0000_0A00, 32'h0, 5'd22, 1);
    run_instr(t, 1, 32'h0BAD_F00D, model(t, 32'h0BAD_F00D), "post_rst");

    // Random traffic against the reference model
    for (int i = 0; i < 250; i++) begin
      dsel = $urandom_range(0, 3);
      t.ld = (dsel == 1) || (dsel == 3);
      t.st = (dsel == 2) || (dsel == 3);
      if ($urandom_range(0, 4) == 0) t.f3 = 3'($urandom_range(0, 7));
      else begin
        case ($urandom_range(0, 4))
          0: t.f3 = 3'b000;
          1: t.f3 = 3'b001;
          2: t.f3 = 3'b010;
          3: t.f3 = 3'b100;
          default: t.f3 = 3'b101;
        endcase
      end
      t.alu = $urandom; t.sd = $urandom; t.rd = 5'($urandom); t.rw = 1'($urandom);
      rd_word = $urandom;
      dsel  = $urandom_range(0, 7);
      delay = (dsel < 6) ? (dsel % 3) : int'(TMO) + dsel - 6;
      e = model(t, rd_word);
      run_instr(t, delay, rd_word, e, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 3) == 0) idle_check($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
